// File: rtl/proc_sequencer_pkg.sv
// Shared types for the distributed-processor sequencer: FSM states, jump
// encodings and the decode/strobe bundles carried from DECODE to COMMIT.
package proc_sequencer_pkg;

   typedef enum logic [3:0] {
      S_IDLE,
      S_FETCH,
      S_DECODE,
      S_ALU_WAIT,
      S_PULSE_WAIT,
      S_SYNC_WAIT,
      S_FPROC_WAIT,
      S_COMMIT,
      S_DONE
   } state_t;

   localparam logic [1:0] INSTR_PTR_LOAD_EN_NONE   = 2'b00;
   localparam logic [1:0] INSTR_PTR_LOAD_EN_UNCOND = 2'b01;
   localparam logic [1:0] INSTR_PTR_LOAD_EN_ALU    = 2'b10;

   typedef struct packed {
      logic       c_strobe;
      logic       reg_write;
      logic       qclk_load;
      logic [1:0] ip_load;
   } dec_t;

   typedef struct packed {
      logic c_strobe;
      logic reg_write_en;
      logic qclk_load_en;
      logic instr_ptr_en;
      logic instr_ptr_load_en;
   } strobe_t;

   // Exactly one of increment/load fires per committed instruction.
   function automatic strobe_t commit_strobes(dec_t d, logic cond);
      strobe_t s;
      logic    ld;
      ld = (d.ip_load == INSTR_PTR_LOAD_EN_UNCOND) ||
           ((d.ip_load == INSTR_PTR_LOAD_EN_ALU) && cond);
      s.c_strobe          = d.c_strobe;
      s.reg_write_en      = d.reg_write;
      s.qclk_load_en      = d.qclk_load;
      s.instr_ptr_en      = !ld;
      s.instr_ptr_load_en = ld;
      return s;
   endfunction

endpackage

// File: rtl/proc_sequencer_if.sv
// Bundle between the sequencer (master) and its decoder/datapath/qclk/barrier
// environment (slave).
interface proc_sequencer_if
   import proc_sequencer_pkg::*;
   #(parameter int QCLK_WIDTH = 32);

   logic                  start;
   logic                  dec_c_strobe_enable;
   logic                  dec_reg_write_en;
   logic                  dec_qclk_load_en;
   logic [1:0]            dec_instr_ptr_load_en;
   logic                  dec_sync;
   logic                  dec_fproc;
   logic                  dec_done;
   logic                  alu_cond;
   logic [QCLK_WIDTH-1:0] cmd_time;
   logic [QCLK_WIDTH-1:0] qclk_val;
   logic                  sync_ack;
   logic                  fproc_ack;

   logic                  c_strobe;
   logic                  reg_write_en;
   logic                  qclk_load_en;
   logic                  instr_ptr_en;
   logic                  instr_ptr_load_en;
   logic                  sync_req;
   logic                  fproc_req;
   logic                  busy;
   logic                  done;
   logic                  pulse_late;
   state_t                dbg_state;

   // Handshake: a req stays high every cycle until the matching ack is sampled
   // high on a rising edge (an ack in the first req cycle counts); req then
   // drops on that same edge and no further ack is expected.
   modport master (
      input  start, dec_c_strobe_enable, dec_reg_write_en, dec_qclk_load_en,
             dec_instr_ptr_load_en, dec_sync, dec_fproc, dec_done, alu_cond,
             cmd_time, qclk_val, sync_ack, fproc_ack,
      output c_strobe, reg_write_en, qclk_load_en, instr_ptr_en,
             instr_ptr_load_en, sync_req, fproc_req, busy, done, pulse_late,
             dbg_state
   );

   modport slave (
      output start, dec_c_strobe_enable, dec_reg_write_en, dec_qclk_load_en,
             dec_instr_ptr_load_en, dec_sync, dec_fproc, dec_done, alu_cond,
             cmd_time, qclk_val, sync_ack, fproc_ack,
      input  c_strobe, reg_write_en, qclk_load_en, instr_ptr_en,
             instr_ptr_load_en, sync_req, fproc_req, busy, done, pulse_late,
             dbg_state
   );

endinterface

// File: rtl/qclk_time_cmp.sv
// Wrap-aware qclk vs. command-time compare: the modular difference read as
// signed tells whether the command time is now, past (late) or still ahead.
module qclk_time_cmp #(
   parameter int QCLK_WIDTH = 32
) (
   input  logic [QCLK_WIDTH-1:0] qclk_val,
   input  logic [QCLK_WIDTH-1:0] cmd_time,
   output logic                  eq,
   output logic                  late
);

   logic [QCLK_WIDTH-1:0] diff;

   assign diff = qclk_val - cmd_time;
   assign eq   = (diff == '0);
   assign late = !diff[QCLK_WIDTH-1] && !eq;

endmodule

// File: rtl/proc_sequencer.sv
// Per-instruction fetch/decode/wait/commit sequencer; turns level decode
// enables into single-cycle registered commit strobes.
module proc_sequencer
   import proc_sequencer_pkg::*;
   #(
   parameter int QCLK_WIDTH       = 32,
   parameter int MEM_READ_LATENCY = 2
) (
   input logic              clk,
   input logic              reset,
   proc_sequencer_if.master bus
);

   localparam logic [2:0] FETCH_INIT = 3'(MEM_READ_LATENCY - 1);

   state_t     state;
   logic [2:0] fetch_cnt;
   dec_t       dec_q;
   dec_t       dec_in;
   strobe_t    strb;
   logic       sync_req;
   logic       fproc_req;
   logic       busy;
   logic       done;
   logic       pulse_late;
   logic       pulse_first;
   logic       t_eq;
   logic       t_late;

   assign dec_in = '{c_strobe:  bus.dec_c_strobe_enable,
                     reg_write: bus.dec_reg_write_en,
                     qclk_load: bus.dec_qclk_load_en,
                     ip_load:   bus.dec_instr_ptr_load_en};

   qclk_time_cmp #(.QCLK_WIDTH(QCLK_WIDTH)) u_time_cmp (
      .qclk_val (bus.qclk_val),
      .cmd_time (bus.cmd_time),
      .eq       (t_eq),
      .late     (t_late)
   );

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         state       <= S_IDLE;
         fetch_cnt   <= '0;
         dec_q       <= '0;
         strb        <= '0;
         sync_req    <= 1'b0;
         fproc_req   <= 1'b0;
         busy        <= 1'b0;
         done        <= 1'b0;
         pulse_late  <= 1'b0;
         pulse_first <= 1'b0;
      end else begin
         strb <= '0;
         case (state)
            S_IDLE: begin
               if (bus.start) begin
                  state      <= S_FETCH;
                  fetch_cnt  <= FETCH_INIT;
                  busy       <= 1'b1;
                  pulse_late <= 1'b0;
               end
            end
            S_FETCH: begin
               if (fetch_cnt == 3'd0) state <= S_DECODE;
               else fetch_cnt <= fetch_cnt - 3'd1;
            end
            S_DECODE: begin
               dec_q <= dec_in;
               if (bus.dec_done) begin
                  state <= S_DONE;
                  busy  <= 1'b0;
                  done  <= 1'b1;
               end else if (dec_in.c_strobe) begin
                  state       <= S_PULSE_WAIT;
                  pulse_first <= 1'b1;
               end else if (bus.dec_sync) begin
                  state    <= S_SYNC_WAIT;
                  sync_req <= 1'b1;
               end else if (bus.dec_fproc) begin
                  state     <= S_FPROC_WAIT;
                  fproc_req <= 1'b1;
               end else if (dec_in.reg_write || dec_in.qclk_load ||
                            (dec_in.ip_load != INSTR_PTR_LOAD_EN_NONE)) begin
                  state <= S_ALU_WAIT;
               end else begin
                  state <= S_COMMIT;
                  strb  <= commit_strobes(dec_in, bus.alu_cond);
               end
            end
            S_ALU_WAIT: begin
               state <= S_COMMIT;
               strb  <= commit_strobes(dec_q, bus.alu_cond);
            end
            S_PULSE_WAIT: begin
               // Lateness only counts on the first compare; afterwards qclk walks up to the command time.
               pulse_first <= 1'b0;
               if (t_eq || (t_late && pulse_first)) begin
                  state <= S_COMMIT;
                  strb  <= commit_strobes(dec_q, bus.alu_cond);
                  if (!t_eq) pulse_late <= 1'b1;
               end
            end
            S_SYNC_WAIT: begin
               if (bus.sync_ack) begin
                  state    <= S_COMMIT;
                  sync_req <= 1'b0;
                  strb     <= commit_strobes(dec_q, bus.alu_cond);
               end
            end
            S_FPROC_WAIT: begin
               if (bus.fproc_ack) begin
                  state     <= S_COMMIT;
                  fproc_req <= 1'b0;
                  strb      <= commit_strobes(dec_q, bus.alu_cond);
               end
            end
            S_COMMIT: begin
               state     <= S_FETCH;
               fetch_cnt <= FETCH_INIT;
            end
            S_DONE: begin
               if (bus.start) begin
                  state      <= S_FETCH;
                  fetch_cnt  <= FETCH_INIT;
                  busy       <= 1'b1;
                  done       <= 1'b0;
                  pulse_late <= 1'b0;
               end
            end
            default: state <= S_IDLE;
         endcase
      end
   end

   assign bus.c_strobe          = strb.c_strobe;
   assign bus.reg_write_en      = strb.reg_write_en;
   assign bus.qclk_load_en      = strb.qclk_load_en;
   assign bus.instr_ptr_en      = strb.instr_ptr_en;
   assign bus.instr_ptr_load_en = strb.instr_ptr_load_en;
   assign bus.sync_req          = sync_req;
   assign bus.fproc_req         = fproc_req;
   assign bus.busy              = busy;
   assign bus.done              = done;
   assign bus.pulse_late        = pulse_late;
   assign bus.dbg_state         = state;

endmodule

// File: tb/tb_proc_sequencer.sv
// Bench for proc_sequencer: directed and random instructions checked against
// an instruction-level latency/strobe model.
module tb_proc_sequencer;

   localparam int L = 2;
   localparam int W = 32;
   localparam int K_ALU   = 0;
   localparam int K_PULSE = 1;
   localparam int K_SYNC  = 2;
   localparam int K_FPROC = 3;
   localparam int K_DONE  = 4;

   typedef struct {
      int         kind;
      logic       rw;
      logic       ql;
      logic [1:0] jmp;
      logic       cond;
      logic [W-1:0] cmd;
      int         delay;
      logic       noise;
   } instr_t;

   logic clk = 1'b0;
   logic reset;
   int   checks = 0;
   int   failures = 0;
   logic [4:0] exp_q[$];
   logic late_model = 1'b0;

   always #5 clk = ~clk;

   proc_sequencer_if #(.QCLK_WIDTH(W)) bus ();

   proc_sequencer #(.QCLK_WIDTH(W), .MEM_READ_LATENCY(L)) dut (
      .clk   (clk),
      .reset (reset),
      .bus   (bus)
   );

   task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
      checks++;
      assert (obs === exp) else begin
         failures++;
         $error("FAIL %s: got %0h expected %0h", tag, obs, exp);
      end
   endtask

   // qclk advances by one for every clock; all waiting goes through here.
   task automatic step();
      @(negedge clk);
      bus.qclk_val = bus.qclk_val + W'(1);
   endtask

   function automatic logic [9:0] outs();
      return {bus.c_strobe, bus.reg_write_en, bus.qclk_load_en, bus.instr_ptr_en,
              bus.instr_ptr_load_en, bus.sync_req, bus.fproc_req, bus.busy,
              bus.done, bus.pulse_late};
   endfunction

   function automatic instr_t mk(int kind, logic rw, logic ql, logic [1:0] jmp,
                                 logic cond, logic [W-1:0] cmd, int delay, logic noise);
      instr_t t;
      t.kind = kind; t.rw = rw; t.ql = ql; t.jmp = jmp; t.cond = cond;
      t.cmd = cmd; t.delay = delay; t.noise = noise;
      return t;
   endfunction

   function automatic instr_t rand_instr(logic [W-1:0] q);
      instr_t t;
      int r;
      r = int'($urandom_range(0, 9));
      t = mk(K_ALU, 1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)),
             2'($urandom_range(0, 2)), 1'($urandom_range(0, 1)), '0,
             int'($urandom_range(0, 9)), 1'($urandom_range(0, 1)));
      if (r >= 4 && r <= 5) t.kind = K_PULSE;
      if (r == 6) t.kind = K_SYNC;
      if (r == 7) t.kind = K_FPROC;
      if (r == 8) begin t.rw = 1'b0; t.ql = 1'b0; t.jmp = 2'd0; end
      if (r == 9) t.kind = K_DONE;
      if ($urandom_range(0, 3) == 0)
         t.cmd = q + W'(L + 2) - W'($urandom_range(1, 5000));
      else
         t.cmd = q + W'(L + 2) + W'($urandom_range(0, 10));
      return t;
   endfunction

   // Cycles from fetch entry to the visible commit (or DONE) of one instruction.
   function automatic int exp_latency(instr_t t, logic [W-1:0] q_s, output logic late);
      logic signed [W-1:0] d;
      late = 1'b0;
      case (t.kind)
         K_PULSE: begin
            d = q_s + W'(L + 2) - t.cmd;
            if (d > 0) begin
               late = 1'b1;
               return L + 3;
            end
            return L + 3 + int'(-d);
         end
         K_SYNC, K_FPROC: return L + 3 + t.delay;
         K_DONE:          return L + 2;
         default:         return (t.rw || t.ql || t.jmp != 2'd0) ? L + 3 : L + 2;
      endcase
   endfunction

   function automatic logic [4:0] exp_strobes(instr_t t);
      logic ld;
      if (t.kind == K_DONE) return 5'b0;
      ld = (t.jmp == 2'd1) || (t.jmp == 2'd2 && t.cond);
      return {t.kind == K_PULSE, t.rw, t.ql, !ld, ld};
   endfunction

   task automatic apply(input instr_t t);
      bus.dec_done              = (t.kind == K_DONE);
      bus.dec_c_strobe_enable   = (t.kind == K_PULSE) || (t.kind == K_DONE && t.noise);
      bus.dec_sync              = (t.kind == K_SYNC) || (t.kind == K_DONE && t.noise);
      bus.dec_fproc             = (t.kind == K_FPROC) || (t.kind == K_DONE && t.noise);
      bus.dec_reg_write_en      = t.rw;
      bus.dec_qclk_load_en      = t.ql;
      bus.dec_instr_ptr_load_en = t.jmp;
      bus.alu_cond              = t.cond;
      bus.cmd_time              = t.cmd;
   endtask

   task automatic run_instr(input instr_t t, input bit from_start);
      logic [W-1:0] q_s;
      logic [4:0]   vec;
      logic         late;
      logic         late_before;
      int n, got_m, sreq_cnt, freq_cnt, busy_lo;
      apply(t);
      if (from_start) begin
         bus.start  = 1'b1;
         late_model = 1'b0;
      end
      late_before = late_model;
      q_s = bus.qclk_val;
      n = exp_latency(t, q_s, late);
      if (late) late_model = 1'b1;
      exp_q.push_back(exp_strobes(t));
      got_m = 0; sreq_cnt = 0; freq_cnt = 0; busy_lo = 0; vec = '0;
      for (int m = 1; m <= 300; m++) begin
         step();
         if (m == 1) begin
            bus.start = 1'b0;
            check("late_after_fetch", 64'(bus.pulse_late), 64'(late_before));
         end
         vec = {bus.c_strobe, bus.reg_write_en, bus.qclk_load_en, bus.instr_ptr_en,
                bus.instr_ptr_load_en};
         if (bus.sync_req) sreq_cnt++;
         if (bus.fproc_req) freq_cnt++;
         bus.sync_ack  = bus.sync_req && (sreq_cnt == t.delay + 1);
         bus.fproc_ack = bus.fproc_req && (freq_cnt == t.delay + 1);
         if (bus.done) begin got_m = m; break; end
         if (!bus.busy) busy_lo++;
         if (vec != 5'b0) begin got_m = m; break; end
      end
      bus.sync_ack  = 1'b0;
      bus.fproc_ack = 1'b0;
      check("latency", 64'(got_m), 64'(n));
      check("strobes", 64'(vec), 64'(exp_q.pop_front()));
      check("sync_req_cycles", 64'(sreq_cnt), 64'((t.kind == K_SYNC) ? t.delay + 1 : 0));
      check("fproc_req_cycles", 64'(freq_cnt), 64'((t.kind == K_FPROC) ? t.delay + 1 : 0));
      check("pulse_late", 64'(bus.pulse_late), 64'(late_model));
      check("busy_low_cycles", 64'(busy_lo), 64'(0));
      if (t.kind == K_DONE) check("done_state", 64'({bus.busy, bus.done}), 64'(2'b01));
      if (t.kind == K_PULSE && !late)
         check("pulse_eq_edge", 64'(q_s + W'(got_m - 1)), 64'(t.cmd));
   endtask

   initial begin
      instr_t t;
      bit     need_start;
      int     bad;
      reset = 1'b1;
      bus.start = 1'b0; bus.sync_ack = 1'b0; bus.fproc_ack = 1'b0;
      bus.qclk_val = '0;
      apply(mk(K_ALU, 1'b0, 1'b0, 2'd0, 1'b0, '0, 0, 1'b0));
      repeat (3) step();
      check("reset_outputs", 64'(outs()), 64'(0));
      reset = 1'b0;
      step();
      check("idle_outputs", 64'(outs()), 64'(0));

      // nop, on-time pulse, wrapped late pulse, conditional jumps
      run_instr(mk(K_ALU, 1'b0, 1'b0, 2'd0, 1'b0, '0, 0, 1'b0), 1'b1);
      bus.qclk_val = W'(87);
      run_instr(mk(K_PULSE, 1'b0, 1'b0, 2'd0, 1'b0, W'(100), 0, 1'b0), 1'b0);
      bus.qclk_val = W'(2);
      run_instr(mk(K_PULSE, 1'b0, 1'b0, 2'd0, 1'b0, 32'hFFFF_FFF0, 0, 1'b0), 1'b0);
      run_instr(mk(K_ALU, 1'b0, 1'b0, 2'd2, 1'b1, '0, 0, 1'b0), 1'b0);
      run_instr(mk(K_ALU, 1'b0, 1'b0, 2'd2, 1'b0, '0, 0, 1'b0), 1'b0);
      run_instr(mk(K_ALU, 1'b1, 1'b1, 2'd1, 1'b0, '0, 0, 1'b0), 1'b0);
      run_instr(mk(K_SYNC, 1'b0, 1'b0, 2'd0, 1'b0, '0, 7, 1'b0), 1'b0);
      run_instr(mk(K_FPROC, 1'b1, 1'b0, 2'd0, 1'b0, '0, 0, 1'b0), 1'b0);
      // pulse boundaries: exactly on time, late by one, late by the largest positive distance
      run_instr(mk(K_PULSE, 1'b0, 1'b0, 2'd0, 1'b0, bus.qclk_val + W'(L + 2), 0, 1'b0), 1'b0);
      run_instr(mk(K_PULSE, 1'b0, 1'b0, 2'd0, 1'b0, bus.qclk_val + W'(L + 1), 0, 1'b0), 1'b0);
      run_instr(mk(K_PULSE, 1'b1, 1'b0, 2'd0, 1'b0,
                   bus.qclk_val + W'(L + 2) - 32'h7FFF_FFFF, 0, 1'b0), 1'b0);
      run_instr(mk(K_DONE, 1'b1, 1'b1, 2'd1, 1'b1, '0, 0, 1'b1), 1'b0);
      repeat (3) step();
      check("done_hold", 64'(outs()), 64'(10'b00000_00011));

      need_start = 1'b1;
      for (int i = 0; i < 40; i++) begin
         if ($urandom_range(0, 3) == 0) bus.qclk_val = W'($urandom());
         t = rand_instr(bus.qclk_val);
         run_instr(t, need_start);
         need_start = (t.kind == K_DONE);
      end
      run_instr(mk(K_DONE, 1'b0, 1'b0, 2'd0, 1'b0, '0, 0, 1'b0), need_start);

      // reset while waiting on a far-future pulse, with a stray start while busy
      apply(mk(K_PULSE, 1'b1, 1'b0, 2'd1, 1'b0, bus.qclk_val + W'(1000), 0, 1'b0));
      bus.start = 1'b1;
      step();
      bus.start = 1'b0;
      repeat (L + 2) step();
      bus.start = 1'b1;
      step();
      step();
      bus.start = 1'b0;
      check("busy_start_ignored", 64'(outs()), 64'(10'b00000_00100));
      #2 reset = 1'b1;
      #1 check("reset_abort_pulse", 64'(outs()), 64'(0));
      step();
      reset = 1'b0;
      bad = 0;
      repeat (5) begin
         step();
         if (outs() != 10'b0) bad++;
      end
      check("idle_after_reset", 64'(bad), 64'(0));

      // reset while a sync request is outstanding
      apply(mk(K_SYNC, 1'b0, 1'b0, 2'd0, 1'b0, '0, 0, 1'b0));
      bus.start = 1'b1;
      step();
      bus.start = 1'b0;
      repeat (L + 1) step();
      check("sync_req_up", 64'(outs()), 64'(10'b00000_10100));
      #2 reset = 1'b1;
      #1 check("reset_abort_sync", 64'(outs()), 64'(0));
      step();
      reset = 1'b0;
      step();
      check("idle_after_sync_reset", 64'(outs()), 64'(0));

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
